// File: rtl/pattern_gen32.sv
//------------------------------------------------------------------------------
// Module      : pattern_gen32
// Description : 32-bit address/data test-pattern source with valid/ready output.
//               Optional macro INVERT_PASS_EN adds a second, bit-inverted pass.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pattern_gen32 #(
   parameter int          ADDR_W       = 10,
   parameter logic [31:0] LFSR_DEFAULT = 32'h0000_0001
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [31:0]       seed,
   input  logic [ADDR_W-1:0] length,
   input  logic              ready,
   output logic              valid,
   output logic [ADDR_W-1:0] addr,
   output logic [31:0]       data,
   output logic              busy,
   output logic              done,
   output logic              pass
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_RUN  = 2'd1;
   localparam logic [1:0] c_DONE = 2'd2;
   localparam logic [1:0] c_GAP  = 2'd3;

`ifdef INVERT_PASS_EN
   localparam logic c_TWO_PASS = 1'b1;
`else
   localparam logic c_TWO_PASS = 1'b0;
`endif

   logic [1:0]        r_state;
   logic [1:0]        r_mode;
   logic [31:0]       r_seed;
   logic [ADDR_W-1:0] r_last_addr;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_gen;
   logic [31:0]       r_data;
   logic              r_valid;
   logic              r_busy;
   logic              r_done;
   logic              r_pass;

   logic              w_accept;
   logic              w_last;
   logic [ADDR_W-1:0] w_addr_inc;
   logic [31:0]       w_seed_eff;
   logic [31:0]       w_gen_next;
   logic [31:0]       w_first_new;
   logic [31:0]       w_first_lat;

   function automatic logic [31:0] f_zext(input logic [ADDR_W-1:0] a);
      return {{(32-ADDR_W){1'b0}}, a};
   endfunction

   function automatic logic [31:0] f_first(input logic [1:0] m, input logic [31:0] s);
      case (m)
         2'd0:    return 32'h0000_0001;
         2'd1:    return 32'hFFFF_FFFE;
         2'd2:    return s;
         default: return 32'h0000_0000;
      endcase
   endfunction

   function automatic logic [31:0] f_next(input logic [1:0] m, input logic [31:0] d,
                                          input logic [ADDR_W-1:0] a_next);
      case (m)
         2'd0, 2'd1: return {d[30:0], d[31]};
         2'd2:       return {d[30:0], d[31] ^ d[21] ^ d[1] ^ d[0]};
         default:    return f_zext(a_next);
      endcase
   endfunction

   assign w_accept    = r_valid & ready;
   assign w_last      = (r_addr == r_last_addr);
   assign w_addr_inc  = r_addr + ADDR_W'(1);
   assign w_seed_eff  = (seed == 32'h0000_0000) ? LFSR_DEFAULT : seed;
   assign w_gen_next  = f_next(r_mode, r_gen, w_addr_inc);
   assign w_first_new = f_first(mode, w_seed_eff);
   assign w_first_lat = f_first(r_mode, r_seed);

   // r_gen always tracks the pass-0 sequence; the second pass is that word inverted,
   // which keeps the LFSR correct (its feedback is not inversion-symmetric).
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= c_IDLE;
         r_mode      <= 2'd0;
         r_seed      <= 32'h0000_0000;
         r_last_addr <= '0;
         r_addr      <= '0;
         r_gen       <= 32'h0000_0000;
         r_data      <= 32'h0000_0000;
         r_valid     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  if (length != '0) begin
                     r_mode      <= mode;
                     r_seed      <= w_seed_eff;
                     r_last_addr <= length - ADDR_W'(1);
                     r_addr      <= '0;
                     r_gen       <= w_first_new;
                     r_data      <= w_first_new;
                     r_valid     <= 1'b1;
                     r_busy      <= 1'b1;
                     r_pass      <= 1'b0;
                     r_state     <= c_RUN;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= c_DONE;
                  end
               end
            end
            c_RUN: begin
               if (w_accept) begin
                  if (!w_last) begin
                     r_addr <= w_addr_inc;
                     r_gen  <= w_gen_next;
                     r_data <= w_gen_next ^ {32{r_pass}};
                  end else if (c_TWO_PASS && !r_pass) begin
                     r_valid <= 1'b0;
                     r_pass  <= 1'b1;
                     r_addr  <= '0;
                     r_gen   <= w_first_lat;
                     r_data  <= ~w_first_lat;
                     r_state <= c_GAP;
                  end else begin
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_pass  <= 1'b0;
                     r_state <= c_DONE;
                  end
               end
            end
            c_GAP: begin
               r_valid <= 1'b1;
               r_state <= c_RUN;
            end
            default: begin
               // Single-cycle done; start is deliberately not sampled here.
               r_done  <= 1'b0;
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   assign valid = r_valid;
   assign addr  = r_addr;
   assign data  = r_data;
   assign busy  = r_busy;
   assign done  = r_done;
   assign pass  = r_pass;

endmodule

`default_nettype wire

// File: tb/tb_pattern_gen32.sv
//------------------------------------------------------------------------------
// Module      : tb_pattern_gen32
// Description : Directed self-checking bench for pattern_gen32 (honours INVERT_PASS_EN).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pattern_gen32;

   localparam int ADDR_W = 10;

   logic              clk;
   logic              reset_n;
   logic              start;
   logic [1:0]        mode;
   logic [31:0]       seed;
   logic [ADDR_W-1:0] length;
   logic              ready;
   logic              valid;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       data;
   logic              busy;
   logic              done;
   logic              pass;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] exp_q[$];

   pattern_gen32 #(.ADDR_W(ADDR_W), .LFSR_DEFAULT(32'h0000_0001)) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .seed(seed),
      .length(length), .ready(ready), .valid(valid), .addr(addr), .data(data),
      .busy(busy), .done(done), .pass(pass)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // The second pass replays the expected words inverted.
   task automatic dup_pass();
`ifdef INVERT_PASS_EN
      int n = exp_q.size();
      for (int i = 0; i < n; i++) exp_q.push_back(~exp_q[i]);
`endif
   endtask

   task automatic start_run(input logic [1:0] m, input logic [31:0] s, input logic [ADDR_W-1:0] len);
      mode   = m;
      seed   = s;
      length = len;
      start  = 1'b1;
      tick();
      start  = 1'b0;
   endtask

   // Drives ready from rdy_pat, checks each accepted beat against exp_q and stops on done.
   task automatic collect(input string tag, input int len, input logic [31:0] rdy_pat, input int start_cyc);
      int          k        = 0;
      int          last_acc = -1;
      int          done_cyc = -1;
      logic [31:0] held     = 32'h0;
      logic        held_v   = 1'b0;
      logic [31:0] e;
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (done) begin
            done_cyc = cyc;
            break;
         end
         ready = rdy_pat[cyc % 32];
         if (cyc == start_cyc) begin
            start  = 1'b1;
            mode   = 2'd3;
            length = 10'd2;
         end else begin
            start = 1'b0;
         end
         if (held_v) chk({tag, " hold"}, data, held);
         held_v = 1'b0;
         if (valid) begin
            chk({tag, " busy"}, 32'(busy), 32'd1);
            if (ready) begin
               e = (k < exp_q.size()) ? exp_q[k] : 32'hDEAD_BEEF;
               chk({tag, " addr"}, 32'(addr), 32'(k % len));
               chk({tag, " data"}, data, e);
               chk({tag, " pass"}, 32'(pass), 32'(k >= len));
               k++;
               last_acc = cyc;
            end else begin
               held   = data;
               held_v = 1'b1;
            end
         end
         tick();
      end
      start = 1'b0;
      chk({tag, " beats"}, 32'(k), 32'(exp_q.size()));
      chk({tag, " done time"}, 32'(done_cyc), 32'(last_acc + 1));
      chk({tag, " done valid"}, 32'(valid), 32'd0);
      chk({tag, " done busy"}, 32'(busy), 32'd0);
   endtask

   task automatic finish_run(input string tag);
      tick();
      chk({tag, " done width"}, 32'(done), 32'd0);
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      ready   = 1'b0;
      mode    = 2'd0;
      seed    = 32'h0;
      length  = '0;
      tick();
      tick();
      chk("rst valid", 32'(valid), 32'd0);
      chk("rst busy",  32'(busy),  32'd0);
      chk("rst done",  32'(done),  32'd0);
      chk("rst pass",  32'(pass),  32'd0);
      chk("rst addr",  32'(addr),  32'd0);
      chk("rst data",  data,       32'd0);
      reset_n = 1'b1;
      tick();

      exp_q = {32'h1, 32'h2, 32'h4, 32'h8};
      dup_pass();
      start_run(2'd0, 32'h0, 10'd4);
      collect("walk1", 4, 32'hFFFF_FFFF, -1);
      finish_run("walk1");

      exp_q = {32'h1, 32'h3, 32'h6, 32'hD};
      dup_pass();
      start_run(2'd2, 32'h0, 10'd4);
      collect("lfsr0", 4, 32'hFFFF_FFFF, -1);
      finish_run("lfsr0");

      exp_q = {32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFB};
      dup_pass();
      start_run(2'd1, 32'h0, 10'd3);
      collect("walk0 stall", 3, 32'hFFFF_FFF4, -1);
      finish_run("walk0 stall");

      exp_q.delete();
      for (int i = 0; i < 40; i++) exp_q.push_back(32'(i));
      dup_pass();
      start_run(2'd3, 32'h0, 10'd40);
      collect("addr40", 40, 32'hFFFF_FFFF, -1);
      finish_run("addr40");

      exp_q.delete();
      for (int i = 0; i < 40; i++) exp_q.push_back(32'h1 << (i % 32));
      dup_pass();
      start_run(2'd0, 32'h0, 10'd40);
      collect("wrap40", 40, 32'hFFFF_FFFF, -1);
      finish_run("wrap40");

      start_run(2'd0, 32'h0, 10'd0);
      chk("len0 done",  32'(done),  32'd1);
      chk("len0 valid", 32'(valid), 32'd0);
      chk("len0 busy",  32'(busy),  32'd0);
      tick();
      chk("len0 done width", 32'(done),  32'd0);
      chk("len0 valid2",     32'(valid), 32'd0);

      exp_q = {32'h1, 32'h2, 32'h4, 32'h8, 32'h10};
      dup_pass();
      start_run(2'd0, 32'h0, 10'd5);
      collect("midstart", 5, 32'hFFFF_FFFF, 2);
      finish_run("midstart");

      exp_q = {32'h1, 32'h2};
      dup_pass();
      start_run(2'd0, 32'h0, 10'd2);
      collect("b2b first", 2, 32'hFFFF_FFFF, -1);
      mode   = 2'd1;
      length = 10'd3;
      start  = 1'b1;
      tick();
      chk("b2b start ignored", 32'(valid), 32'd0);
      chk("b2b done width",    32'(done),  32'd0);
      tick();
      start = 1'b0;
      chk("b2b start taken", 32'(valid), 32'd1);
      exp_q = {32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFB};
      dup_pass();
      collect("b2b second", 3, 32'hFFFF_FFFF, -1);
      finish_run("b2b second");

      start_run(2'd0, 32'h0, 10'd8);
      ready = 1'b1;
      tick();
      tick();
      chk("midrst beat2 addr", 32'(addr), 32'd2);
      chk("midrst beat2 data", data,      32'h4);
      reset_n = 1'b0;
      tick();
      chk("midrst valid", 32'(valid), 32'd0);
      chk("midrst busy",  32'(busy),  32'd0);
      chk("midrst addr",  32'(addr),  32'd0);
      chk("midrst data",  data,       32'd0);
      chk("midrst done",  32'(done),  32'd0);
      reset_n = 1'b1;
      exp_q = {32'h5, 32'hB, 32'h16};
      dup_pass();
      start_run(2'd2, 32'h5, 10'd3);
      collect("post-rst lfsr", 3, 32'hFFFF_FFFF, -1);
      finish_run("post-rst lfsr");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
